// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit common-anode seven-segment scanner.
// Shows a double-buffered 32-bit hex value, one nibble per digit, and
// blanks every digit for a few cycles at the end of each dwell to
// suppress ghosting.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_SHOW | current digit driven (if its mask bit is set)
//   ST_BLANK| all anodes off, end-of-dwell ghosting gap
module seg7_scan #(
    parameter int CLK_FREQ     = 100000000,
    parameter int SCAN_FREQ    = 8000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        clken,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DWELL    = CLK_FREQ / SCAN_FREQ;
    localparam int SHOW_LEN = DWELL - BLANK_CYCLES;
    localparam int CW       = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(SHOW_LEN);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;

    logic [31:0]     act_data;
    logic [7:0]      act_dp;
    logic [7:0]      act_mask;
    logic [31:0]     pend_data;
    logic [7:0]      pend_dp;
    logic [7:0]      pend_mask;
    logic            pend_valid;

    logic [CW-1:0]   cnt_nxt;
    logic            cnt_wrap;
    logic            boundary;
    logic [3:0]      cur_nib;
    logic [6:0]      seg_dec;
    logic [7:0]      an_sel;
    logic            digit_on;

    // Dwell counter step and frame boundary detection.
    always_comb begin
        cnt_wrap = (cnt == CNT_LAST);
        cnt_nxt  = cnt_wrap ? '0 : cnt + 1'b1;
        boundary = clken && cnt_wrap && (idx == 3'd7);
    end

    // Select the current digit's nibble and anode, decode to {g..a} active low.
    always_comb begin
        cur_nib  = act_data[{idx, 2'b00} +: 4];
        an_sel   = ~(8'd1 << idx);
        digit_on = (state == ST_SHOW) && act_mask[idx];
        case (cur_nib)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    // Scan FSM with registered outputs; outputs lag the scan state by one cycle.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state      <= ST_SHOW;
            cnt        <= '0;
            idx        <= 3'd0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (clken) begin
            frame_done <= boundary;
            if (digit_on) begin
                an  <= an_sel;
                seg <= seg_dec;
                dp  <= ~act_dp[idx];
            end else begin
                an  <= 8'hFF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
            cnt <= cnt_nxt;
            if (cnt_wrap) begin
                idx <= idx + 3'd1;
            end
            state <= (cnt_nxt < CNT_SHOW) ? ST_SHOW : ST_BLANK;
        end else begin
            frame_done <= 1'b0;
        end
    end

    // Double buffer: writes land in pending and are promoted only at a frame
    // boundary; a write in the boundary cycle itself goes straight to active.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            act_data   <= 32'd0;
            act_dp     <= 8'd0;
            act_mask   <= 8'd0;
            pend_data  <= 32'd0;
            pend_dp    <= 8'd0;
            pend_mask  <= 8'd0;
            pend_valid <= 1'b0;
        end else if (wr_en && boundary) begin
            act_data   <= wr_data;
            act_dp     <= wr_dp;
            act_mask   <= wr_mask;
            pend_valid <= 1'b0;
        end else if (wr_en) begin
            pend_data  <= wr_data;
            pend_dp    <= wr_dp;
            pend_mask  <= wr_mask;
            pend_valid <= 1'b1;
        end else if (boundary && pend_valid) begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_mask   <= pend_mask;
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed frame-by-frame bench for seg7_scan
// (DWELL=10, SHOW=8, frame=80 cycles).
module tb_seg7_scan;

    logic        clkin = 1'b0;
    logic        rst_n;
    logic        clken;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [7:0]  wr_dp;
    logic [7:0]  wr_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan #(
        .CLK_FREQ    (1000),
        .SCAN_FREQ   (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .clken     (clken),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .wr_mask   (wr_mask),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    // expected display contents and pending buffer
    logic [31:0] m_data, p_data;
    logic [7:0]  m_dp, m_mask, p_dp, p_mask;
    logic        p_valid;

    // per-frame schedule; step 0 means unused
    int          w1_t, w2_t, hold_t, rst_t;
    logic [47:0] w1_v, w2_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
            4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
            4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
            4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
        endcase
        return r;
    endfunction

    // expected {an,seg,dp} sampled after step t (1..80) of a frame
    function automatic logic [15:0] exp_out(input int t);
        int         d;
        int         c;
        logic [7:0] onehot;
        d = (t - 1) / 10;
        c = (t - 1) % 10;
        onehot = 8'd1 << d;
        if (c < 8 && m_mask[d])
            return {~onehot, hex7(m_data[d*4 +: 4]), ~m_dp[d]};
        return 16'hFFFF;
    endfunction

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic clear_sched();
        w1_t = 0; w2_t = 0; hold_t = 0; rst_t = 0;
    endtask

    // Run one 80-cycle frame from just after a boundary (or reset) edge.
    task automatic run_frame(input string name);
        logic [15:0] e;
        logic [15:0] last_e;
        logic        wr_now;
        logic [47:0] wv;
        last_e = 16'hFFFF;
        for (int t = 1; t <= 80; t++) begin
            if (t == rst_t) begin
                wr_en = 1'b0;
                rst_n = 1'b0;
                tick();
                check($sformatf("%s reset out", name), {16'd0, an, seg, dp}, 32'h0000FFFF);
                check($sformatf("%s reset fd", name), {31'd0, frame_done}, 32'd0);
                m_data = '0; m_dp = '0; m_mask = '0; p_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                clear_sched();
                return;
            end
            if (t == hold_t) begin
                wr_en = 1'b0;
                clken = 1'b0;
                for (int k = 0; k < 25; k++) begin
                    tick();
                    check($sformatf("%s hold%0d out", name, k), {16'd0, an, seg, dp}, {16'd0, last_e});
                    check($sformatf("%s hold%0d fd", name, k), {31'd0, frame_done}, 32'd0);
                end
                clken = 1'b1;
            end
            wr_now = 1'b0;
            wv = '0;
            if (t == w1_t) begin wr_now = 1'b1; wv = w1_v; end
            else if (t == w2_t) begin wr_now = 1'b1; wv = w2_v; end
            wr_en = wr_now;
            {wr_data, wr_dp, wr_mask} = wv;
            e = exp_out(t);
            tick();
            check($sformatf("%s t%0d out", name, t), {16'd0, an, seg, dp}, {16'd0, e});
            check($sformatf("%s t%0d fd", name, t), {31'd0, frame_done}, {31'd0, t == 80});
            if (wr_now && t == 80) begin
                {m_data, m_dp, m_mask} = wv;
                p_valid = 1'b0;
            end else if (wr_now) begin
                {p_data, p_dp, p_mask} = wv;
                p_valid = 1'b1;
            end else if (t == 80 && p_valid) begin
                m_data = p_data; m_dp = p_dp; m_mask = p_mask;
                p_valid = 1'b0;
            end
            last_e = e;
        end
        wr_en = 1'b0;
        clear_sched();
    endtask

    initial begin
        rst_n = 1'b0; clken = 1'b1; wr_en = 1'b0;
        wr_data = '0; wr_dp = '0; wr_mask = '0;
        m_data = '0; m_dp = '0; m_mask = '0;
        p_data = '0; p_dp = '0; p_mask = '0; p_valid = 1'b0;
        clear_sched();
        w1_v = '0; w2_v = '0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("por out", {16'd0, an, seg, dp}, 32'h0000FFFF);
            check("por fd", {31'd0, frame_done}, 32'd0);
        end
        rst_n = 1'b1;

        // idle after reset: dark, frame_done every 80 cycles
        run_frame("idle1");
        run_frame("idle2");

        // queue 89ABCDEF for the next frame
        w1_t = 5; w1_v = {32'h89ABCDEF, 8'h01, 8'hFF};
        run_frame("wr1");

        // shows 89ABCDEF; two mid-frame writes, last one wins
        w1_t = 20; w1_v = {32'h12345678, 8'h00, 8'hFF};
        w2_t = 45; w2_v = {32'h0000000F, 8'h00, 8'hFF};
        run_frame("show1");

        // shows 0000000F; write in the boundary cycle bypasses pending
        w1_t = 80; w1_v = {32'h0000000A, 8'h00, 8'h01};
        run_frame("show2");

        // shows A on digit 0 only; queue 76543210 with dp on digit 3
        w1_t = 10; w1_v = {32'h76543210, 8'h08, 8'hFF};
        run_frame("bypass");

        // clken low for 25 cycles mid-SHOW of digit 3
        hold_t = 34;
        run_frame("hold");

        // pending write queued, then reset during digit 5
        w1_t = 30; w1_v = {32'hFFFFFFFF, 8'hFF, 8'hFF};
        rst_t = 55;
        run_frame("rstmid");

        // pending write must have been discarded
        run_frame("postrst1");
        run_frame("postrst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Drives the board's 8-digit common-anode seven-segment display from a 32-bit hex value.
- Consumer stage for the system clock / enable produced by the clock-generation block, so that register contents written by the processor appear on the display.
- Time-multiplexes the digits and inserts a blanking gap between digits to suppress ghosting.
- Double-buffers writes so that every frame shows exactly one value, with no mixing of old and new digits.

Parameters:
- CLK_FREQ, 100000000: clkin frequency in Hz.
- SCAN_FREQ, 8000: digit rate in Hz. DWELL = CLK_FREQ/SCAN_FREQ cycles per digit.
- BLANK_CYCLES, 100: cycles at the end of each dwell during which all digits are off.
- Legal range: 1 <= BLANK_CYCLES < DWELL.

Ports:
- clkin  in  1  system clock, the single clock domain.
- rst_n  in  1  synchronous reset, active low.
- clken  in  1  scan enable; when low, the scan freezes.
- wr_en  in  1  one-cycle write strobe.
- wr_data  in  32  hex value; nibble i goes to digit i.
- wr_dp  in  8  decimal-point mask; 1 = dp lit.
- wr_mask  in  8  digit enable mask; 1 = digit shown.
- an  out  8  anode selects, active low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n=0 sampled at a clkin edge):
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
  - Internal state: digit index 0, state SHOW, dwell counter 0.
  - Buffers: active={data 0, dp 0, mask 0}; pending cleared with pending_valid=0.
  - Reset mid-frame aborts the scan immediately.
- State machine, per digit:
  - SHOW lasts DWELL-BLANK_CYCLES cycles.
  - BLANK lasts BLANK_CYCLES cycles.
  - The dwell counter runs 0..DWELL-1. At DWELL-1 the counter wraps to 0 and the digit index advances (7 wraps to 0).
  - State is SHOW when counter < DWELL-BLANK_CYCLES, otherwise BLANK.
- clken:
  - clken=0 holds the counter, index and state, and holds the outputs.
  - frame_done is 0 while clken=0.
  - Writes are still accepted while clken=0.
- Outputs are registered: the outputs in cycle n+1 reflect the state in cycle n.
- Display rules:
  - SHOW with active mask[i]=1: an has only bit i low; seg = decode(active data[4i+3:4i]); dp = ~active dp[i].
  - BLANK, or mask[i]=0: an=8'hFF, seg=7'h7F, dp=1.
- Hex decode table (hex, {g..a}):
  - 0→40, 1→79, 2→24, 3→30
  - 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03
  - C→46, d→21, E→06, F→0E
- Writes:
  - wr_en=1 loads {wr_data, wr_dp, wr_mask} into pending and sets pending_valid.
  - A later write before the boundary overwrites pending; the last write wins.
- Frame boundary: the cycle in which digit 7 counter = DWELL-1 and clken=1.
  - If pending_valid, active <= pending and pending_valid <= 0.
  - frame_done is registered 1 for exactly the next cycle.
- Write in the boundary cycle: active loads wr_data/wr_dp/wr_mask directly (bypass) and pending_valid <= 0. That value is displayed from digit 0 of the new frame.
- Frame length is 8*DWELL cycles of clken=1. There is no other latency path.

Test Plan:
Parameters for all scenarios: CLK_FREQ=1000, SCAN_FREQ=100, BLANK_CYCLES=2, so DWELL=10 and SHOW=8 cycles.
1. Reset held for 3 cycles, then released with no writes → an=FF, seg=7F, dp=1 at every cycle; frame_done pulses every 80 cycles.
2. Write 32'h89ABCDEF, dp=8'h01, mask=FF, then wait for the boundary → frame shows:
   - Digit 0: an=FE, seg=0E, dp=0, for 8 cycles, then 2 cycles of an=FF.
   - Digit 1: an=FD, seg=06.
   - Digit 7: an=7F, seg=00.
3. Two writes mid-frame (12345678, then 0000000F, mask=FF) → current frame unchanged; next frame digit 0 seg=0E and digits 1–7 seg=40.
4. Write asserted exactly in the boundary cycle with value 0000000A, mask=01 → next frame digit 0 seg=08; digits 1–7 dark; no frame delay.
5. clken=0 for 25 cycles mid-SHOW of digit 3 → an/seg frozen at the digit 3 values, no frame_done; the dwell resumes from the same count afterwards.
6. rst_n=0 during digit 5 with a pending write queued → outputs dark next cycle; the pending write is discarded; the display stays dark after release.
